// File: rtl/serial_compare_ctrl_pkg.sv
// Shared definitions for the serial compare sequencer: FSM states,
// 2-bit result codes and the code-to-flag decoder.
package serial_compare_ctrl_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] RES_GT = 2'd0;
    localparam logic [1:0] RES_EQ = 2'd1;
    localparam logic [1:0] RES_LT = 2'd2;

    // Decode a result code into the one-hot {gt, eq, lt} flag set.
    function automatic logic [2:0] res_flags(input logic [1:0] code);
        logic [2:0] f;
        f = '0;
        case (code)
            RES_GT:  f = 3'b100;
            RES_EQ:  f = 3'b010;
            RES_LT:  f = 3'b001;
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/serial_compare_ctrl_slice.sv
// Purely combinational 2-bit unsigned magnitude comparator slice.
// x = {a1,a0} > {b1,b0}, y = equal, z = less-than.
module cmp_slice_2bit (
    input  logic a1,
    input  logic a0,
    input  logic b1,
    input  logic b0,
    output logic x,
    output logic y,
    output logic z
);

    logic hi_eq;

    // Compare MSB first; the LSB only decides when the MSBs match.
    always_comb begin
        hi_eq = ~(a1 ^ b1);
        x     = (a1 & ~b1) | (hi_eq & a0 & ~b0);
        y     = hi_eq & ~(a0 ^ b0);
        z     = (~a1 & b1) | (hi_eq & ~a0 & b0);
    end

endmodule

// File: rtl/serial_compare_ctrl.sv
// Serial magnitude comparator: steps one 2-bit slice over the captured
// operands, MSB pair first, with a start/busy/done handshake and abort.
module serial_compare_ctrl
    import serial_compare_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NSLICE = WIDTH / 2;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IDXW-1:0]  idx;
    logic             decided, gt_s;

    logic [1:0] a_pair, b_pair;
    logic       s_gt, s_eq, s_lt;
    logic       accept, finish, last_pair, early_hit;
    logic [1:0] fin_code;

    assign a_pair = a_q[2*idx +: 2];
    assign b_pair = b_q[2*idx +: 2];

    cmp_slice_2bit u_slice (
        .a1 (a_pair[1]),
        .a0 (a_pair[0]),
        .b1 (b_pair[1]),
        .b0 (b_pair[0]),
        .x  (s_gt),
        .y  (s_eq),
        .z  (s_lt)
    );

    // Control decode: acceptance, completion and the final result code.
    // A pair decided earlier (sticky when not exiting early) outranks the
    // slice currently being examined.
    always_comb begin
        accept    = (state == S_IDLE) && start;
        last_pair = (idx == '0);
        early_hit = EARLY_EXIT && !s_eq;
        finish    = (state == S_RUN) && !abort && (early_hit || last_pair);
        if (decided)   fin_code = gt_s ? RES_GT : RES_LT;
        else if (s_gt) fin_code = RES_GT;
        else if (s_lt) fin_code = RES_LT;
        else           fin_code = RES_EQ;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: abort outranks completion while running.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)       state_nxt = S_RUN;
            S_RUN:   if (abort)       state_nxt = S_IDLE;
                     else if (finish) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        busy = (state == S_RUN);
    end

    // Operand capture, slice index, sticky decision and result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            idx     <= '0;
            decided <= 1'b0;
            gt_s    <= 1'b0;
            done    <= 1'b0;
            gt      <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                idx     <= IDXW'(NSLICE - 1);
                decided <= 1'b0;
                gt_s    <= 1'b0;
            end else if ((state == S_RUN) && !abort && !finish) begin
                idx <= idx - 1'b1;
                if (!decided && !s_eq) begin
                    decided <= 1'b1;
                    gt_s    <= s_gt;
                end
            end
            if (finish) {gt, eq, lt} <= res_flags(fin_code);
        end
    end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Scoreboard bench for serial_compare_ctrl: one instance with early exit,
// one without; directed vectors plus a random sweep against a reference.
module tb_serial_compare_ctrl;

    typedef struct {
        logic [2:0]  flags;
        int unsigned due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, start0 = 1'b0;
    logic       abort = 1'b0, abort0 = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy1, done1, gt1, eq1, lt1;
    logic       busy0, done0, gt0, eq0, lt0;

    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        q1[$];
    exp_t        q0[$];

    serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .a(a), .b(b),
        .busy(busy1), .done(done1), .gt(gt1), .eq(eq1), .lt(lt1)
    );

    serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .a(a), .b(b),
        .busy(busy0), .done(done0), .gt(gt0), .eq(eq0), .lt(lt0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    // Monitor for the early-exit instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            assert (!(done1 && busy1));
            assert ($onehot0({gt1, eq1, lt1}));
            if (done1) begin
                total++;
                if (q1.size() == 0) begin
                    bad++;
                    $display("FAIL ee1_unexpected_done: cyc=%0d flags=%b", cyc, {gt1, eq1, lt1});
                end else begin
                    e = q1.pop_front();
                    if ({gt1, eq1, lt1} !== e.flags || cyc != e.due || busy1 !== 1'b0) begin
                        bad++;
                        $display("FAIL ee1_result: flags=%b cyc=%0d busy=%b, expected flags=%b cyc=%0d busy=0",
                                 {gt1, eq1, lt1}, cyc, busy1, e.flags, e.due);
                    end
                end
            end
        end
    end

    // Monitor for the full-length instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            assert (!(done0 && busy0));
            assert ($onehot0({gt0, eq0, lt0}));
            if (done0) begin
                total++;
                if (q0.size() == 0) begin
                    bad++;
                    $display("FAIL ee0_unexpected_done: cyc=%0d flags=%b", cyc, {gt0, eq0, lt0});
                end else begin
                    e = q0.pop_front();
                    if ({gt0, eq0, lt0} !== e.flags || cyc != e.due || busy0 !== 1'b0) begin
                        bad++;
                        $display("FAIL ee0_result: flags=%b cyc=%0d busy=%b, expected flags=%b cyc=%0d busy=0",
                                 {gt0, eq0, lt0}, cyc, busy0, e.flags, e.due);
                    end
                end
            end
        end
    end

    function automatic int unsigned pairs_examined(input logic [7:0] av, input logic [7:0] bv,
                                                   input bit ee);
        logic [7:0] x;
        x = av ^ bv;
        if (!ee)       return 4;
        if (x[7:6] != 0) return 1;
        if (x[5:4] != 0) return 2;
        if (x[3:2] != 0) return 3;
        return 4;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    // Issue one compare at the first idle cycle; start is dropped right after E0.
    task automatic issue(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                         input logic [2:0] ef, input int unsigned k, input bit expect_done);
        int unsigned n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while ((sel ? busy0 : busy1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: busy still 1 after %0d cycles, expected 0", n);
        end
        a = av;
        b = bv;
        if (sel) start0 = 1'b1;
        else     start  = 1'b1;
        if (expect_done) begin
            e.flags = ef;
            e.due   = cyc + 1 + k;
            if (sel) q0.push_back(e);
            else     q1.push_back(e);
        end
        @(posedge clk);
        #1;
        start  = 1'b0;
        start0 = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while ((q1.size() != 0 || q0.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        check("scoreboard_empty", 8'(q1.size() + q0.size()), 8'd0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        exp_t e;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ee1", {3'b0, busy1, done1, gt1, eq1, lt1}, 8'd0);
        check("reset_ee0", {3'b0, busy0, done0, gt0, eq0, lt0}, 8'd0);
        rst = 1'b0;

        // 1: equal operands run the full four pairs
        issue(0, 8'hA5, 8'hA5, 3'b010, 4, 1);
        check("t1_busy_after_e0", {7'b0, busy1}, 8'd1);
        drain();

        // 2: MSB pair differs; early exit vs full run
        issue(0, 8'h80, 8'h7F, 3'b100, 1, 1);
        issue(1, 8'h80, 8'h7F, 3'b100, 4, 1);
        issue(0, 8'h40, 8'h3F, 3'b100, 1, 1);
        issue(0, 8'hFF, 8'hFE, 3'b100, 4, 1);
        issue(1, 8'h00, 8'h00, 3'b010, 4, 1);
        issue(1, 8'h01, 8'h02, 3'b001, 4, 1);
        drain();

        // 3: start held high restarts on the done cycle
        @(negedge clk);
        a = 8'h12;
        b = 8'h13;
        start = 1'b1;
        e.flags = 3'b001; e.due = cyc + 1 + 4;     q1.push_back(e);
        e.flags = 3'b001; e.due = cyc + 1 + 4 + 5; q1.push_back(e);
        repeat (6) @(posedge clk);
        #1;
        start = 1'b0;
        drain();

        // 4: start while busy is ignored
        issue(0, 8'h00, 8'hFF, 3'b001, 1, 1);
        @(negedge clk);
        check("t4_busy_when_restarting", {7'b0, busy1}, 8'd1);
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        check("t4_flags_held", {5'b0, gt1, eq1, lt1}, 8'b001);

        // 5: abort at E2 -> no done, flags kept
        issue(0, 8'h33, 8'h33, 3'b000, 4, 0);
        @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("t5_busy_after_abort", {7'b0, busy1}, 8'd0);
        check("t5_flags_kept", {5'b0, gt1, eq1, lt1}, 8'b001);

        // Start+abort while idle: start wins; abort on the completing edge wins
        abort = 1'b1;
        issue(0, 8'h80, 8'h7F, 3'b000, 1, 0);
        check("start_beats_idle_abort", {7'b0, busy1}, 8'd1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_beats_finish_busy", {7'b0, busy1}, 8'd0);
        check("abort_beats_finish_flags", {5'b0, gt1, eq1, lt1}, 8'b001);
        drain();

        // 6: reset mid-run clears everything at once
        issue(0, 8'hA5, 8'hA5, 3'b000, 4, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_reset_mid_run", {3'b0, busy1, done1, gt1, eq1, lt1}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(0, 8'h12, 8'h34, 3'b001, 2, 1);
        drain();

        // Random sweep against a reference compare
        for (int i = 0; i < 1500; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i % 4 == 0) rb = ra;
            else if (i % 4 == 1) rb = {ra[7:2], rb[1:0]};
            issue(0, ra, rb, {ra > rb, ra == rb, ra < rb}, pairs_examined(ra, rb, 1'b1), 1);
        end
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i % 3 == 0) rb = ra;
            issue(1, ra, rb, {ra > rb, ra == rb, ra < rb}, pairs_examined(ra, rb, 1'b0), 1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
